// File: rtl/game_pkg.sv
// Shared definitions for the maze game flow controller.
//   game_state_e : FSM state encoding, also driven out on game_state
//   move_dir_e   : move direction encoding, driven out on move_dir
//   H_TOTAL/V_TOTAL : VGA raster dimensions
//   pick_dir()   : fixed-priority direction select (up > down > left > right)
package game_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StWin  = 2'd2,
        StLose = 2'd3
    } game_state_e;

    typedef enum logic [1:0] {
        DirUp    = 2'd0,
        DirDown  = 2'd1,
        DirLeft  = 2'd2,
        DirRight = 2'd3
    } move_dir_e;

    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned V_TOTAL  = 525;
    localparam int unsigned STEP_MAX = 4095;

    // lvl bit order: [0] up, [1] down, [2] left, [3] right
    function automatic move_dir_e pick_dir(input logic [3:0] lvl);
        if (lvl[0]) begin
            return DirUp;
        end else if (lvl[1]) begin
            return DirDown;
        end else if (lvl[2]) begin
            return DirLeft;
        end else begin
            return DirRight;
        end
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer plus registered rising-edge detector for one button.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   btn_i   : raw asynchronous button level
//   level_o : synchronized level (2 cycles after btn_i)
//   rise_o  : one-cycle pulse on a synchronized rising edge (3 cycles after btn_i)
module btn_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    logic sync1_q, sync2_q, prev_q, rise_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rise_q  <= sync2_q & ~prev_q;
        end
    end

    assign level_o = sync2_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: title/play/win/lose FSM, countdown timer and
// frame-paced move requests to the player datapath (req/ack handshake).
//   CLOCK_25, reset_n          : clock, asynchronous active-low reset
//   h_counter, v_counter       : VGA raster position (frame start at 0,0)
//   btn_up/down/left/right     : raw buttons
//   goal_hit, alt_end          : end-of-game events from the player
//   move_ack, move_blocked     : handshake response from the player
//   move_req, move_dir         : move request and its direction
//   enable_player, end_game_1/2: PLAY / WIN / LOSE indicators
//   time_left, step_count      : remaining seconds, accepted moves
//   game_state                 : current FSM state
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned MOVE_PERIOD    = 2,
    parameter int unsigned FRAMES_PER_SEC = 60,
    parameter int unsigned TIME_LIMIT     = 120,
    parameter int unsigned HOLD_FRAMES    = 120
) (
    input  logic        CLOCK_25,
    input  logic        reset_n,
    input  logic [9:0]  h_counter,
    input  logic [9:0]  v_counter,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        goal_hit,
    input  logic        alt_end,
    input  logic        move_ack,
    input  logic        move_blocked,
    output logic        move_req,
    output logic [1:0]  move_dir,
    output logic        enable_player,
    output logic        end_game_1,
    output logic        end_game_2,
    output logic [7:0]  time_left,
    output logic [11:0] step_count,
    output logic [1:0]  game_state
);

    localparam int unsigned SecW  = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam int unsigned DivW  = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam int unsigned HoldW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    localparam logic [SecW-1:0]  SecLast  = SecW'(FRAMES_PER_SEC - 1);
    localparam logic [DivW-1:0]  DivLast  = DivW'(MOVE_PERIOD - 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(HOLD_FRAMES);
    localparam logic [7:0]       TimeInit = 8'(TIME_LIMIT);
    localparam logic [11:0]      StepSat  = 12'(STEP_MAX);

    logic [3:0] lvl, rise;

    btn_sync u_sync_up (
        .clk_i(CLOCK_25), .rst_ni(reset_n), .btn_i(btn_up),    .level_o(lvl[0]), .rise_o(rise[0])
    );
    btn_sync u_sync_down (
        .clk_i(CLOCK_25), .rst_ni(reset_n), .btn_i(btn_down),  .level_o(lvl[1]), .rise_o(rise[1])
    );
    btn_sync u_sync_left (
        .clk_i(CLOCK_25), .rst_ni(reset_n), .btn_i(btn_left),  .level_o(lvl[2]), .rise_o(rise[2])
    );
    btn_sync u_sync_right (
        .clk_i(CLOCK_25), .rst_ni(reset_n), .btn_i(btn_right), .level_o(lvl[3]), .rise_o(rise[3])
    );

    game_state_e      state_q;
    move_dir_e        move_dir_q;
    logic             frame_tick_q;
    logic [SecW-1:0]  sec_cnt_q;
    logic [DivW-1:0]  move_div_q;
    logic [HoldW-1:0] hold_cnt_q;
    logic [7:0]       time_left_q;
    logic [11:0]      step_count_q;
    logic             move_req_q, enable_q, end1_q, end2_q;

    logic sec_wrap, timeout, opportunity, ack_ok, any_rise, any_level;

    always_comb begin
        sec_wrap    = frame_tick_q && (sec_cnt_q == SecLast);
        // Decrement to zero and the timeout exit happen on the same edge.
        timeout     = (time_left_q == 8'd0) || (sec_wrap && (time_left_q == 8'd1));
        opportunity = frame_tick_q && (move_div_q == DivLast) && !move_req_q;
        ack_ok      = move_req_q && move_ack;
        any_rise    = |rise;
        any_level   = |lvl;
    end

    always_ff @(posedge CLOCK_25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            move_dir_q   <= DirUp;
            frame_tick_q <= 1'b0;
            sec_cnt_q    <= '0;
            move_div_q   <= '0;
            hold_cnt_q   <= '0;
            time_left_q  <= TimeInit;
            step_count_q <= '0;
            move_req_q   <= 1'b0;
            enable_q     <= 1'b0;
            end1_q       <= 1'b0;
            end2_q       <= 1'b0;
        end else begin
            frame_tick_q <= (h_counter == 10'd0) && (v_counter == 10'd0);
            unique case (state_q)
                StIdle: begin
                    if (any_rise) begin
                        state_q      <= StPlay;
                        enable_q     <= 1'b1;
                        time_left_q  <= TimeInit;
                        step_count_q <= '0;
                        sec_cnt_q    <= '0;
                        move_div_q   <= '0;
                    end
                end
                StPlay: begin
                    if (frame_tick_q) begin
                        sec_cnt_q  <= sec_wrap ? '0 : sec_cnt_q + 1'b1;
                        move_div_q <= (move_div_q == DivLast) ? '0 : move_div_q + 1'b1;
                        if (sec_wrap && time_left_q != 8'd0) begin
                            time_left_q <= time_left_q - 8'd1;
                        end
                    end
                    if (ack_ok) begin
                        move_req_q <= 1'b0;
                        if (!move_blocked && step_count_q != StepSat) begin
                            step_count_q <= step_count_q + 12'd1;
                        end
                    end else if (opportunity && any_level) begin
                        move_req_q <= 1'b1;
                        move_dir_q <= pick_dir(lvl);
                    end
                    // Exit overrides any request issued this cycle.
                    if (goal_hit || alt_end || timeout) begin
                        move_req_q <= 1'b0;
                        enable_q   <= 1'b0;
                        hold_cnt_q <= '0;
                        if (goal_hit) begin
                            state_q <= StWin;
                            end1_q  <= 1'b1;
                        end else begin
                            state_q <= StLose;
                            end2_q  <= 1'b1;
                        end
                    end
                end
                StWin, StLose: begin
                    if (frame_tick_q && hold_cnt_q != HoldMax) begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                    if (hold_cnt_q == HoldMax && any_rise) begin
                        state_q <= StIdle;
                        end1_q  <= 1'b0;
                        end2_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign move_req      = move_req_q;
    assign move_dir      = move_dir_q;
    assign enable_player = enable_q;
    assign end_game_1    = end1_q;
    assign end_game_2    = end2_q;
    assign time_left     = time_left_q;
    assign step_count    = step_count_q;
    assign game_state    = state_q;

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Game-flow controller for the maze game. It sits between the raw buttons and the player datapath. It owns the title → play → win/lose state machine and the countdown timer, and converts button levels into frame-paced, one-at-a-time move requests to the player with a req/ack handshake. All decisions are taken on frame boundaries derived from the VGA counters, so movement speed and timing are independent of button bounce.

## Interface
Parameters:
- MOVE_PERIOD, 2, frames between successive move-request opportunities (≥1)
- FRAMES_PER_SEC, 60, frame ticks per timer second
- TIME_LIMIT, 120, seconds loaded into time_left at game start (≤255)
- HOLD_FRAMES, 120, minimum frames spent in WIN/LOSE before a restart is accepted

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- CLOCK_25  input  1  pixel clock; sole clock of the block
- reset_n  input  1  asynchronous active-low reset
- h_counter  input  10  VGA horizontal counter (0..799)
- v_counter  input  10  VGA vertical counter (0..524)
- btn_up, btn_down, btn_left, btn_right  input  1 each  raw active-high buttons, asynchronous to CLOCK_25
- goal_hit  input  1  player overlaps the objective house
- alt_end  input  1  player left the maze through the alternate exit
- move_ack  input  1  player accepted the current move request (one-cycle pulse)
- move_blocked  input  1  valid with move_ack; move rejected by collision
- move_req  output  1  move request, held until acknowledged
- move_dir  output  2  0 up, 1 down, 2 left, 3 right; stable while move_req=1
- enable_player  output  1  high only in PLAY
- end_game_1  output  1  high in WIN
- end_game_2  output  1  high in LOSE
- time_left  output  8  remaining seconds
- step_count  output  12  accepted (unblocked) moves this game, saturating
- game_state  output  2  current FSM state

## Operation
- Buttons: each button passes through a two-flop synchronizer. A rising-edge pulse is produced from the synchronized level.
- frame_tick: a one-cycle pulse, registered, in the cycle after h_counter==0 && v_counter==0.
- FSM states: IDLE=0, PLAY=1, WIN=2, LOSE=3.
  - IDLE → PLAY on any synchronized button rising edge. On entry: time_left=TIME_LIMIT, step_count=0, frame dividers cleared.
  - In PLAY, exit conditions are checked every cycle. Priority is goal_hit > alt_end > timeout.
  - PLAY → WIN on goal_hit.
  - PLAY → LOSE on alt_end, or when time_left reaches 0.
  - WIN/LOSE: hold_cnt counts frame_ticks from 0, saturating at HOLD_FRAMES. Once hold_cnt==HOLD_FRAMES, any button rising edge → IDLE. Edges before that are ignored.
- Timer: in PLAY, sec_cnt counts frame_ticks 0..FRAMES_PER_SEC-1. At wrap, time_left decrements. The decrement to 0 and the PLAY→LOSE transition occur on the same clock edge. time_left never underflows.
- Move scheduling:
  - move_div counts frame_ticks 0..MOVE_PERIOD-1 in PLAY.
  - A move opportunity is a frame_tick with move_div==MOVE_PERIOD-1, in PLAY, with move_req=0.
  - At an opportunity, if any synchronized button level is high, move_req=1 and move_dir is taken by fixed priority up > down > left > right.
  - move_req clears on move_ack. If move_blocked=0 at ack, step_count increments, saturating at 4095.
  - Leaving PLAY clears move_req immediately; a late move_ack is then ignored.
  - move_ack while move_req=0 is ignored.

## Timing
- Reset values: game_state=IDLE, move_req=0, move_dir=0, enable_player=0, end_game_1=0, end_game_2=0, time_left=TIME_LIMIT, step_count=0. All internal counters and synchronizers are 0.
- All outputs are registered.
- Button to edge pulse: 3 cycles (2 sync + edge register).
- Frame-counter condition to frame_tick: 1 cycle.
- frame_tick at an opportunity to move_req high: 1 cycle.
- move_ack to move_req low: 1 cycle. A new request is issued no earlier than the next opportunity.
- goal_hit/alt_end to end_game_x: 1 cycle. enable_player falls on the same edge.
- Simultaneous goal_hit and time expiry → WIN.
- Simultaneous move_ack and a state exit → the exit is taken and step_count is still updated.
- reset_n asserted mid-game → immediate return to reset values, regardless of handshake state.

## Structure
- Shared package game_pkg: state encoding, direction encoding, H_TOTAL=800, V_TOTAL=525.
- Sub-module btn_sync: two-flop synchronizer plus rising-edge detector, instantiated four times.
- FSM, timer, move divider and handshake live in game_sequencer.

## Test plan
- Reset release, no buttons for 3 frames → state IDLE, enable_player=0, time_left=120, move_req=0.
- btn_right pulse in IDLE → PLAY within 4 cycles, step_count=0. Hold btn_up and btn_right, ack after 5 cycles with move_blocked=0 → move_dir=0, move_req issued every 2nd frame, step_count +1 per ack.
- TIME_LIMIT=2, FRAMES_PER_SEC=3, no goal → time_left 2→1→0 on frames 3 and 6; LOSE on the edge where 0 is reached; end_game_2=1.
- goal_hit and alt_end asserted in the same cycle → WIN, end_game_1=1, end_game_2=0, move_req dropped.
- In WIN with HOLD_FRAMES=4: button edge at frame 2 ignored; button edge at frame 5 → IDLE. Next edge → PLAY with time_left reloaded.
- move_blocked=1 on ack → step_count unchanged. reset_n low while move_req=1 → move_req=0 the same cycle.
